// File: rtl/tx_window_scheduler.sv
// Cyclic transmit-window scheduler: phase counter over a programmable period,
// guard/start/finish pulses for the TX selector and per-window frame quota.
module tx_window_scheduler #(
  parameter int unsigned CNT_WIDTH     = 32,
  parameter int unsigned PKT_CNT_WIDTH = 16
) (
  input  logic                     axis_aclk,
  input  logic                     axis_resetn,
  input  logic                     cfg_enable,
  input  logic [CNT_WIDTH-1:0]     cfg_period,
  input  logic [CNT_WIDTH-1:0]     cfg_offset,
  input  logic [CNT_WIDTH-1:0]     cfg_window_len,
  input  logic [CNT_WIDTH-1:0]     cfg_guard_band,
  input  logic [PKT_CNT_WIDTH-1:0] cfg_max_pkts,
  input  logic                     mon_tvalid,
  input  logic                     mon_tready,
  input  logic                     mon_tlast,
  output logic                     pkt_gen_ready,
  output logic                     tx_signal,
  output logic                     pkt_gen_finish,
  output logic                     window_open,
  output logic [PKT_CNT_WIDTH-1:0] sent_pkt_count,
  output logic [CNT_WIDTH-1:0]     phase,
  output logic                     cfg_error,
  output logic                     overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_GUARD, S_OPEN, S_DRAIN, S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_WIDTH-1:0]     phase_q, phase_d;
  logic [PKT_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                     fin_pend_q, fin_pend_d;
  logic                     mid_pkt_q;
  logic                     cfg_err_q;
  logic [CNT_WIDTH-1:0]     period_q, offset_q, len_q, guard_q;
  logic [PKT_CNT_WIDTH-1:0] max_q;

  logic                     hs, frame_done, run, wrap;
  logic [CNT_WIDTH-1:0]     start_ph, end_ph;
  logic [CNT_WIDTH:0]       end_sum;
  logic [PKT_CNT_WIDTH-1:0] cnt_inc;
  logic                     load, ready, tx, close, fin_now, ovr, quota;

  function automatic logic cfg_ok(input logic [CNT_WIDTH-1:0] per,
                                  input logic [CNT_WIDTH-1:0] off,
                                  input logic [CNT_WIDTH-1:0] len,
                                  input logic [CNT_WIDTH-1:0] grd);
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, off} + {1'b0, len};
    return (per >= CNT_WIDTH'(2)) && (len != '0) && (off >= grd) && (sum <= {1'b0, per});
  endfunction

  assign hs         = mon_tvalid & mon_tready;
  assign frame_done = hs & mon_tlast;
  assign run        = cfg_enable & ~cfg_err_q;
  assign wrap       = (phase_q == period_q - CNT_WIDTH'(1));
  assign start_ph   = offset_q - guard_q;
  assign end_sum    = {1'b0, offset_q} + {1'b0, len_q};
  // A window ending exactly at the period boundary closes on phase 0.
  assign end_ph     = (end_sum == {1'b0, period_q}) ? '0 : end_sum[CNT_WIDTH-1:0];
  assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + PKT_CNT_WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    fin_pend_d = 1'b0;
    load       = 1'b0;
    ready      = 1'b0;
    tx         = 1'b0;
    close      = 1'b0;
    fin_now    = 1'b0;
    ovr        = 1'b0;
    if (state_q != S_IDLE) begin
      load    = wrap;
      phase_d = wrap ? '0 : phase_q + CNT_WIDTH'(1);
    end
    unique case (state_q)
      S_IDLE: begin
        phase_d = '0;
        if (cfg_enable) begin
          load = 1'b1;
          if (cfg_ok(cfg_period, cfg_offset, cfg_window_len, cfg_guard_band)) state_d = S_WAIT;
        end
      end
      S_WAIT, S_DONE: begin
        if (!run) state_d = S_IDLE;
        else if (phase_q == start_ph) begin
          ready = 1'b1;
          if (guard_q == '0) tx = 1'b1;
          else state_d = S_GUARD;
        end
      end
      S_GUARD: begin
        if (!run) close = 1'b1;
        else if (phase_q == offset_q) tx = 1'b1;
      end
      S_OPEN: begin
        if (frame_done) cnt_d = cnt_inc;
        if (!run || phase_q == end_ph) close = 1'b1;
      end
      S_DRAIN: begin
        if (frame_done) begin
          cnt_d      = cnt_inc;
          fin_pend_d = 1'b1;
          state_d    = run ? S_DONE : S_IDLE;
        end else if (run && phase_q == start_ph) begin
          ovr = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (tx) begin
      cnt_d   = PKT_CNT_WIDTH'(frame_done);
      state_d = S_OPEN;
    end
    // Quota wins over a simultaneous window close so only one finish is issued.
    quota = (tx || state_q == S_OPEN) && frame_done && (max_q != '0) && (cnt_d == max_q);
    if (quota) begin
      fin_pend_d = 1'b1;
      state_d    = run ? S_DONE : S_IDLE;
    end else if (close) begin
      if (mid_pkt_q && !frame_done) state_d = S_DRAIN;
      else begin
        fin_now = 1'b1;
        state_d = run ? S_DONE : S_IDLE;
      end
    end
    if (state_d == S_IDLE) phase_d = '0;
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      cnt_q      <= '0;
      fin_pend_q <= 1'b0;
      mid_pkt_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
      period_q   <= '0;
      offset_q   <= '0;
      len_q      <= '0;
      guard_q    <= '0;
      max_q      <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      fin_pend_q <= fin_pend_d;
      if (hs) mid_pkt_q <= ~mon_tlast;
      if (load) begin
        period_q  <= cfg_period;
        offset_q  <= cfg_offset;
        len_q     <= cfg_window_len;
        guard_q   <= cfg_guard_band;
        max_q     <= cfg_max_pkts;
        cfg_err_q <= ~cfg_ok(cfg_period, cfg_offset, cfg_window_len, cfg_guard_band);
      end
    end
  end

  assign pkt_gen_ready  = ready;
  assign tx_signal      = tx;
  assign pkt_gen_finish = fin_pend_q | fin_now;
  assign window_open    = tx | ((state_q == S_OPEN) & ~close);
  assign sent_pkt_count = cnt_q;
  assign phase          = phase_q;
  assign cfg_error      = cfg_err_q;
  assign overrun        = ovr;

endmodule

// File: tb/tb_tx_window_scheduler.sv
// Bench for tx_window_scheduler: directed schedule scenarios plus randomized
// configuration/traffic checked cycle by cycle against a behavioural model.
module tb_tx_window_scheduler;
  localparam int CW = 32;
  localparam int PW = 16;
  localparam longint CNT_MAX = 65535;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic          cfg_enable;
  logic [CW-1:0] cfg_period, cfg_offset, cfg_window_len, cfg_guard_band;
  logic [PW-1:0] cfg_max_pkts;
  logic          mon_tvalid, mon_tready, mon_tlast;
  logic          pkt_gen_ready, tx_signal, pkt_gen_finish, window_open, cfg_error, overrun;
  logic [PW-1:0] sent_pkt_count;
  logic [CW-1:0] phase;

  tx_window_scheduler #(.CNT_WIDTH(CW), .PKT_CNT_WIDTH(PW)) dut (
    .axis_aclk(clk), .axis_resetn(rstn), .cfg_enable(cfg_enable),
    .cfg_period(cfg_period), .cfg_offset(cfg_offset), .cfg_window_len(cfg_window_len),
    .cfg_guard_band(cfg_guard_band), .cfg_max_pkts(cfg_max_pkts),
    .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
    .pkt_gen_ready(pkt_gen_ready), .tx_signal(tx_signal), .pkt_gen_finish(pkt_gen_finish),
    .window_open(window_open), .sent_pkt_count(sent_pkt_count), .phase(phase),
    .cfg_error(cfg_error), .overrun(overrun)
  );

  logic [6+PW+CW-1:0] obs, exp_v;
  assign obs = {pkt_gen_ready, tx_signal, pkt_gen_finish, window_open, overrun, cfg_error,
                sent_pkt_count, phase};

  int checks = 0;
  int failures = 0;

  // Staged configuration, applied to the DUT at the start of each tick.
  bit     s_en;
  longint s_per, s_off, s_len, s_grd, s_max;

  // Behavioural model: scheduler active flag, window stage flags, counters.
  bit     m_act, m_err, m_armed, m_open, m_drain, m_fin, m_mid;
  longint m_ph, m_per, m_off, m_len, m_grd, m_max, m_cnt;
  bit     e_ready, e_tx, e_fin, e_win, e_ovr;

  function automatic bit cfg_valid(longint p, longint o, longint l, longint g);
    return (p >= 2) && (l >= 1) && (o >= g) && (o + l <= p);
  endfunction

  task automatic model_reset();
    m_act = 0; m_err = 0; m_armed = 0; m_open = 0; m_drain = 0; m_fin = 0; m_mid = 0;
    m_ph = 0; m_per = 0; m_off = 0; m_len = 0; m_grd = 0; m_max = 0; m_cnt = 0;
  endtask

  task automatic model_cycle();
    bit hs, fd, run, wrap, opening, stop, leave, do_latch;
    bit n_act, n_err, n_armed, n_open, n_drain, n_fin, n_mid;
    longint n_ph, n_cnt, n_per, n_off, n_len, n_grd, n_max, start, endp;
    hs = mon_tvalid && mon_tready;
    fd = hs && mon_tlast;
    n_act = m_act; n_err = m_err; n_armed = m_armed; n_open = m_open; n_drain = m_drain;
    n_mid = m_mid; n_ph = m_ph; n_cnt = m_cnt;
    n_per = m_per; n_off = m_off; n_len = m_len; n_grd = m_grd; n_max = m_max;
    e_ready = 0; e_tx = 0; e_fin = m_fin; e_win = 0; e_ovr = 0;
    n_fin = 0; opening = 0; stop = 0; leave = 0; do_latch = 0;
    if (!m_act) begin
      n_ph = 0;
      if (cfg_enable) begin
        do_latch = 1;
        n_act = cfg_valid(s_per, s_off, s_len, s_grd);
      end
    end else begin
      run = cfg_enable && !m_err;
      wrap = (m_ph == m_per - 1);
      n_ph = wrap ? 0 : m_ph + 1;
      do_latch = wrap;
      start = m_off - m_grd;
      endp = (m_off + m_len == m_per) ? 0 : m_off + m_len;
      if (!m_armed && !m_open && !m_drain) begin
        if (!run) leave = 1;
        else if (m_ph == start) begin
          e_ready = 1;
          if (m_grd == 0) opening = 1; else n_armed = 1;
        end
      end
      if (m_armed) begin
        if (!run) begin stop = 1; n_armed = 0; end
        else if (m_ph == m_off) begin opening = 1; n_armed = 0; end
      end
      if (m_open) begin
        if (fd) n_cnt = (m_cnt == CNT_MAX) ? m_cnt : m_cnt + 1;
        if (m_ph == endp || !run) stop = 1; else e_win = 1;
      end
      if (opening) begin e_tx = 1; e_win = 1; n_open = 1; n_cnt = fd ? 1 : 0; end
      if ((opening || m_open) && fd && m_max != 0 && n_cnt == m_max) begin
        n_open = 0; n_fin = 1; leave = !run;
      end else if (stop) begin
        n_open = 0;
        if (m_mid && !fd) n_drain = 1;
        else begin e_fin = 1; leave = !run; end
      end
      if (m_drain) begin
        if (fd) begin
          n_cnt = (m_cnt == CNT_MAX) ? m_cnt : m_cnt + 1;
          n_drain = 0; n_fin = 1; leave = !run;
        end else if (run && m_ph == start) e_ovr = 1;
      end
      if (leave) begin n_act = 0; n_ph = 0; n_armed = 0; n_open = 0; n_drain = 0; end
    end
    if (do_latch) begin
      n_per = s_per; n_off = s_off; n_len = s_len; n_grd = s_grd; n_max = s_max;
      n_err = !cfg_valid(s_per, s_off, s_len, s_grd);
    end
    if (hs) n_mid = !mon_tlast;
    exp_v = {e_ready, e_tx, e_fin, e_win, e_ovr, m_err, PW'(m_cnt), CW'(m_ph)};
    m_act = n_act; m_err = n_err; m_armed = n_armed; m_open = n_open; m_drain = n_drain;
    m_fin = n_fin; m_mid = n_mid; m_ph = n_ph; m_cnt = n_cnt;
    m_per = n_per; m_off = n_off; m_len = n_len; m_grd = n_grd; m_max = n_max;
  endtask

  // One clock: apply inputs at the falling edge, let them settle, evaluate the model.
  task automatic tick(input bit v, input bit r, input bit l);
    @(negedge clk);
    cfg_enable = s_en;
    cfg_period = CW'(s_per); cfg_offset = CW'(s_off); cfg_window_len = CW'(s_len);
    cfg_guard_band = CW'(s_grd); cfg_max_pkts = PW'(s_max);
    mon_tvalid = v; mon_tready = r; mon_tlast = l;
    #1;
    model_cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    s_en = 0; cfg_enable = 0; mon_tvalid = 0; mon_tready = 0; mon_tlast = 0;
    rstn = 0;
    #1;
    model_reset();
    @(negedge clk);
    rstn = 1;
  endtask

  task automatic set_cfg(longint p, longint o, longint l, longint g, longint m);
    s_per = p; s_off = o; s_len = l; s_grd = g; s_max = m;
  endtask

  task automatic test_reset();
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", obs); end
    @(negedge clk);
    rstn = 1;
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0);
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL reset_idle tick=%0d got=%h exp=%h", i, obs, exp_v); end
    end
  endtask

  task automatic test_basic_schedule();
    int n_ready = 0, n_fin = 0, n_open = 0;
    do_reset();
    set_cfg(100, 40, 30, 10, 0);
    s_en = 1;
    for (int i = 0; i < 280; i++) begin
      tick(0, 0, 0);
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL basic tick=%0d got=%h exp=%h", i, obs, exp_v); end
      if (pkt_gen_ready) begin
        n_ready++; checks++;
        if (phase !== 30) begin failures++; $display("FAIL basic_ready_phase got=%0d exp=30", phase); end
      end
      if (tx_signal) begin
        checks++;
        if (phase !== 40) begin failures++; $display("FAIL basic_tx_phase got=%0d exp=40", phase); end
      end
      if (pkt_gen_finish) begin
        n_fin++; checks++;
        if (phase !== 70) begin failures++; $display("FAIL basic_finish_phase got=%0d exp=70", phase); end
      end
      if (window_open) n_open++;
    end
    checks++;
    if (n_ready != 3 || n_fin != 3 || n_open != 90) begin
      failures++;
      $display("FAIL basic_counts got ready=%0d fin=%0d open=%0d exp 3 3 90", n_ready, n_fin, n_open);
    end
  endtask

  task automatic test_quota();
    bit v, l;
    do_reset();
    set_cfg(100, 40, 30, 10, 3);
    s_en = 1;
    for (int i = 0; i < 120; i++) begin
      v = (i >= 42 && i <= 65);
      l = v && ((i - 42) % 8 == 7);
      tick(v, 1, l);
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL quota tick=%0d got=%h exp=%h", i, obs, exp_v); end
      if (i == 65) begin
        checks++;
        if (window_open !== 1 || sent_pkt_count !== 2 || pkt_gen_finish !== 0) begin
          failures++; $display("FAIL quota_last_tlast got open=%b cnt=%0d fin=%b exp 1 2 0", window_open, sent_pkt_count, pkt_gen_finish);
        end
      end
      if (i == 66) begin
        checks++;
        if (pkt_gen_finish !== 1 || sent_pkt_count !== 3 || window_open !== 0) begin
          failures++; $display("FAIL quota_finish got fin=%b cnt=%0d open=%b exp 1 3 0", pkt_gen_finish, sent_pkt_count, window_open);
        end
      end
      if (i == 71) begin
        checks++;
        if (pkt_gen_finish !== 0) begin failures++; $display("FAIL quota_single_finish got=%b exp=0", pkt_gen_finish); end
      end
    end
  endtask

  task automatic test_guard_zero();
    do_reset();
    set_cfg(20, 0, 5, 0, 0);
    s_en = 1;
    for (int i = 0; i < 62; i++) begin
      tick(0, 0, 0);
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL guard0 tick=%0d got=%h exp=%h", i, obs, exp_v); end
      if (i == 1 || i == 21 || i == 41) begin
        checks++;
        if (pkt_gen_ready !== 1 || tx_signal !== 1 || phase !== 0) begin
          failures++; $display("FAIL guard0_same_cycle tick=%0d got rdy=%b tx=%b ph=%0d exp 1 1 0", i, pkt_gen_ready, tx_signal, phase);
        end
      end
    end
  endtask

  task automatic test_drain();
    bit v, l;
    do_reset();
    set_cfg(100, 40, 30, 10, 0);
    s_en = 1;
    for (int i = 0; i < 110; i++) begin
      v = (i >= 67 && i <= 73);
      l = (i == 73);
      tick(v, 1, l);
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL drain tick=%0d got=%h exp=%h", i, obs, exp_v); end
      if (i == 71 || i == 73) begin
        checks++;
        if (pkt_gen_finish !== 0 || window_open !== 0) begin
          failures++; $display("FAIL drain_no_early_finish tick=%0d got fin=%b open=%b exp 0 0", i, pkt_gen_finish, window_open);
        end
      end
      if (i == 74) begin
        checks++;
        if (pkt_gen_finish !== 1 || sent_pkt_count !== 1) begin
          failures++; $display("FAIL drain_finish got fin=%b cnt=%0d exp 1 1", pkt_gen_finish, sent_pkt_count);
        end
      end
    end
  endtask

  task automatic test_overrun();
    bit v, l;
    do_reset();
    set_cfg(100, 40, 30, 10, 0);
    s_en = 1;
    for (int i = 0; i < 245; i++) begin
      v = (i == 67 || i == 151);
      l = (i == 151);
      tick(v, 1, l);
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL overrun tick=%0d got=%h exp=%h", i, obs, exp_v); end
      if (i == 131) begin
        checks++;
        if (overrun !== 1 || pkt_gen_ready !== 0) begin
          failures++; $display("FAIL overrun_pulse got ovr=%b rdy=%b exp 1 0", overrun, pkt_gen_ready);
        end
      end
      if (i == 141) begin
        checks++;
        if (tx_signal !== 0) begin failures++; $display("FAIL overrun_no_tx got=%b exp=0", tx_signal); end
      end
      if (i == 152) begin
        checks++;
        if (pkt_gen_finish !== 1) begin failures++; $display("FAIL overrun_finish got=%b exp=1", pkt_gen_finish); end
      end
      if (i == 231) begin
        checks++;
        if (pkt_gen_ready !== 1) begin failures++; $display("FAIL overrun_resume got=%b exp=1", pkt_gen_ready); end
      end
    end
  endtask

  task automatic test_cfg_error();
    do_reset();
    set_cfg(100, 5, 30, 10, 0);
    s_en = 1;
    for (int i = 0; i < 30; i++) begin
      tick(0, 0, 0);
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL cfgerr tick=%0d got=%h exp=%h", i, obs, exp_v); end
    end
    checks++;
    if (cfg_error !== 1 || phase !== 0) begin
      failures++; $display("FAIL cfgerr_level got err=%b ph=%0d exp 1 0", cfg_error, phase);
    end
  endtask

  task automatic test_enable_fall();
    int n_fin = 0;
    do_reset();
    set_cfg(100, 40, 30, 10, 0);
    s_en = 1;
    for (int i = 0; i < 70; i++) begin
      if (i == 51) s_en = 0;
      tick(0, 0, 0);
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL enfall tick=%0d got=%h exp=%h", i, obs, exp_v); end
      if (i >= 51 && pkt_gen_finish) n_fin++;
      if (i == 51) begin
        checks++;
        if (pkt_gen_finish !== 1 || window_open !== 0) begin
          failures++; $display("FAIL enfall_finish got fin=%b open=%b exp 1 0", pkt_gen_finish, window_open);
        end
      end
    end
    checks++;
    if (n_fin != 1 || phase !== 0) begin
      failures++; $display("FAIL enfall_idle got fins=%0d ph=%0d exp 1 0", n_fin, phase);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_cfg(100, 40, 30, 10, 0);
    s_en = 1;
    for (int i = 0; i < 50; i++) tick(0, 0, 0);
    checks++;
    if (window_open !== 1) begin failures++; $display("FAIL rstmid_open got=%b exp=1", window_open); end
    #2;
    rstn = 0;
    #1;
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL rstmid_outputs got=%h exp=0", obs); end
    model_reset();
    do_reset();
  endtask

  task automatic rand_cfg();
    s_per = $urandom_range(40, 2);
    s_len = $urandom_range(s_per, 1);
    s_off = $urandom_range(s_per - s_len, 0);
    s_grd = $urandom_range(s_off, 0);
    s_max = $urandom_range(4, 0);
    if ($urandom_range(9, 0) == 0) s_grd = s_off + 1;
  endtask

  task automatic test_random();
    bit v, r, l;
    for (int c = 0; c < 6; c++) begin
      do_reset();
      rand_cfg();
      s_en = 1;
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(79, 0) == 0) s_en = !s_en;
        if ($urandom_range(149, 0) == 0) rand_cfg();
        v = ($urandom_range(2, 0) != 0);
        r = ($urandom_range(3, 0) != 0);
        l = ($urandom_range(4, 0) == 0);
        tick(v, r, l);
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL random c=%0d tick=%0d got=%h exp=%h", c, i, obs, exp_v); end
      end
    end
  endtask

  initial begin
    rstn = 0;
    s_en = 0; cfg_enable = 0;
    set_cfg(0, 0, 0, 0, 0);
    cfg_period = '0; cfg_offset = '0; cfg_window_len = '0; cfg_guard_band = '0; cfg_max_pkts = '0;
    mon_tvalid = 0; mon_tready = 0; mon_tlast = 0;
    model_reset();
    #3;
    test_reset();
    test_basic_schedule();
    test_quota();
    test_guard_zero();
    test_drain();
    test_overrun();
    test_cfg_error();
    test_enable_fall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
